alu_add_arbiter: RTL
====================

Name: alu_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 5-bit ripple adder (`alu_add`) between NUM_REQ requesters.
- Accepts one request per transaction over a valid/ready handshake and registers the operands.
- Drives the single shared adder instance and returns the registered sum and carry-out, tagged with the requester ID, over a valid/ready response channel.
- Sits between the ALU front-end requesters and the adder datapath.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of requester ID; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid; bit i = requester i.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_operand_a  input  5*NUM_REQ  flattened operand A; requester i uses bits [5i+4:5i].
- req_operand_b  input  5*NUM_REQ  flattened operand B; same packing as req_operand_a.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  downstream accepts response.
- rsp_id  output  ID_W  index of the requester the response belongs to.
- rsp_result  output  5  operand_a + operand_b, modulo 32.
- rsp_carry_out  output  1  carry out of bit 4.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- One clock domain. Reset is synchronous and active-high: it is sampled only on the rising edge of clk.
- Reset values:
  - state = IDLE; req_ready = 0; rsp_valid = 0; rsp_id = 0; rsp_result = 0; rsp_carry_out = 0; busy = 0.
  - Internal operand registers = 0.
  - Priority pointer last_grant = NUM_REQ-1, so requester 0 has top priority after reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, select winner w = the first set bit searching upward from (last_grant+1) mod NUM_REQ, wrapping around.
  - req_ready[w] = 1 combinationally in this cycle; all other req_ready bits = 0. The handshake completes this cycle.
  - At the clock edge: latch the operands of w, set rsp_id <= w and last_grant <= w, go to EXEC.
  - If no req_valid bit is set: req_ready = 0 and remain in IDLE.
- EXEC:
  - Latched operands drive the adder; operand_b carry-in is 0.
  - At the clock edge: register the adder outputs into rsp_result/rsp_carry_out, set rsp_valid <= 1, go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid = 1. rsp_id, rsp_result and rsp_carry_out are held stable until the handshake completes.
  - When rsp_valid && rsp_ready: at the clock edge clear rsp_valid and go to IDLE.
  - req_ready = 0 throughout, so back-pressure stalls all requesters.
- Latency and throughput:
  - Request accepted in cycle T; rsp_valid first high in T+2.
  - Peak throughput is one transaction per 3 cycles, with rsp_ready held high.
- Requester rules:
  - A requester holds req_valid and its operands stable until it sees its req_ready bit.
  - Deasserting req_valid before grant is legal; that request simply drops out of arbitration.
- Fairness:
  - A continuously asserting requester is served at least once every NUM_REQ transactions.
  - last_grant updates only on an accepted request.
- Arithmetic:
  - 6-bit sum; rsp_result = sum[4:0], rsp_carry_out = sum[5].
  - Example: 31 + 1 gives result 0, carry_out 1.
- Reset mid-operation, in EXEC or RESP:
  - The in-flight transaction is discarded and no response is issued.
  - All outputs return to their reset values on the next edge.
  - Priority returns to requester 0.
- rsp_ready high while in IDLE or EXEC has no effect.

Test Plan:
- Reset, then requester 2 only: req_valid=0100, a=7, b=9 -> req_ready=0100 in the same cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_result=16, rsp_carry_out=0.
- Overflow: requester 0, a=31, b=1 -> rsp_result=0, rsp_carry_out=1; a=31, b=31 -> rsp_result=30, rsp_carry_out=1.
- All four requesters held valid with rsp_ready=1 -> grant order 0,1,2,3,0; a new grant every 3 cycles; rsp_id matches the grant order.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_result stable, req_ready=0, busy=1; release -> return to IDLE, next grant follows round-robin order.
- Reset asserted one cycle after a grant, while in EXEC -> no rsp_valid pulse; all outputs 0 after the edge; with requesters 1 and 3 then valid, the first grant goes to 1.
- Requester 1 drops req_valid while requester 3 is being served -> 1 is not granted afterwards; with 0 and 3 valid and last_grant=3, the next grant goes to 0.

Source files
------------

// File: rtl/alu_add_arbiter.sv
// alu_add_arbiter: round-robin arbiter sharing one 5-bit ripple adder between NUM_REQ requesters
module alu_add (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       cin,
  output logic [4:0] sum,
  output logic       cout
);
  logic [5:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 5; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[5];
endmodule

module alu_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [5*NUM_REQ-1:0] req_operand_a,
  input  logic [5*NUM_REQ-1:0] req_operand_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [4:0]           rsp_result,
  output logic                 rsp_carry_out,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t          state, next_state;
  logic [ID_W-1:0] last_grant, win;
  logic            found;
  logic [4:0]      op_a, op_b, sum;
  logic            cout;
  logic [4:0]      a_arr [NUM_REQ];
  logic [4:0]      b_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_operand_a[5*i +: 5];
    assign b_arr[i] = req_operand_b[5*i +: 5];
  end
  alu_add u_add (.a(op_a), .b(op_b), .cin(1'b0), .sum(sum), .cout(cout));
  always_comb begin
    win   = last_grant;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[ID_W'((int'(last_grant) + k) % NUM_REQ)]) begin
        win   = ID_W'((int'(last_grant) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    next_state = state == IDLE ? (found ? EXEC : IDLE) :
                 state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
    req_ready  = (state == IDLE && found) ? NUM_REQ'(1) << win : '0;
    busy       = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= ID_W'(NUM_REQ - 1);
      op_a          <= '0;
      op_b          <= '0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_carry_out <= 1'b0;
      rsp_valid     <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && found) begin
        op_a       <= a_arr[win];
        op_b       <= b_arr[win];
        rsp_id     <= win;
        last_grant <= win;
      end
      if (state == EXEC) begin
        rsp_result    <= sum;
        rsp_carry_out <= cout;
        rsp_valid     <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule
